// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit add/subtract; carry ripples through CHUNK-bit slices, one register stage per slice.
// Latency: STAGES = WIDTH/CHUNK cycles from acceptance to out_valid; one result per cycle.
// Backpressure: global stall; nothing moves while out_valid && !out_ready, and in_ready = !out_valid || out_ready.
// Optional: define ADDER_OVERFLOW_FLAG_EN to add the registered signed-overflow output ovf.
module pipelined_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  // Guarded so a bad parameter set still elaborates far enough to report the error.
  localparam int STAGES = ((CHUNK > 0) && (WIDTH >= CHUNK)) ? (WIDTH / CHUNK) : 1;

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("pipelined_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end

  // Per-stage state: valid, carry out of this stage's slice, operands still to be
  // consumed downstream, and the partial result with slices 0..k filled in.
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic             cry_q [STAGES];
  logic             cry_d [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opa_d [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  logic [WIDTH-1:0] res_q [STAGES];
  logic [WIDTH-1:0] res_d [STAGES];
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic             ovf_q;
  logic             ovf_d;
`endif
  logic             adv;

  // Next-state for every stage: ripple one slice, carry the rest forward, or hold on stall.
  always_comb begin : stage_next
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_r;
    logic             in_c;
    logic             in_v;
    logic [CHUNK:0]   ext;
    adv      = !vld_q[STAGES-1] || out_ready;
    in_ready = adv;
    in_a     = '0;
    in_b     = '0;
    in_r     = '0;
    in_c     = 1'b0;
    in_v     = 1'b0;
    ext      = '0;
`ifdef ADDER_OVERFLOW_FLAG_EN
    ovf_d    = ovf_q;
`endif
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        // Subtract is a + ~b + 1; cin is deliberately ignored in that mode.
        in_a = a;
        in_b = sub ? ~b : b;
        in_c = sub | cin;
        in_r = '0;
        in_v = in_valid;
      end else begin
        in_a = opa_q[(k > 0) ? k - 1 : 0];
        in_b = opb_q[(k > 0) ? k - 1 : 0];
        in_c = cry_q[(k > 0) ? k - 1 : 0];
        in_r = res_q[(k > 0) ? k - 1 : 0];
        in_v = vld_q[(k > 0) ? k - 1 : 0];
      end
      ext = {1'b0, in_a[k*CHUNK +: CHUNK]} + {1'b0, in_b[k*CHUNK +: CHUNK]}
          + {{CHUNK{1'b0}}, in_c};
      vld_d[k] = vld_q[k];
      cry_d[k] = cry_q[k];
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      res_d[k] = res_q[k];
      if (adv) begin
        // Bubbles shift exactly like real entries; only the valid bit tells them apart.
        vld_d[k] = in_v;
        cry_d[k] = ext[CHUNK];
        opa_d[k] = in_a;
        opb_d[k] = in_b;
        res_d[k] = in_r;
        res_d[k][k*CHUNK +: CHUNK] = ext[CHUNK-1:0];
`ifdef ADDER_OVERFLOW_FLAG_EN
        // Carry into the MSB is recovered from the MSB sum bit and its operands.
        if (k == STAGES - 1) begin
          ovf_d = in_a[WIDTH-1] ^ in_b[WIDTH-1] ^ ext[CHUNK-1] ^ ext[CHUNK];
        end
`endif
      end
    end
  end

  // Pipeline registers; reset flushes every in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
      end
`ifdef ADDER_OVERFLOW_FLAG_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        cry_q[k] <= cry_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        res_q[k] <= res_d[k];
      end
`ifdef ADDER_OVERFLOW_FLAG_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = cry_q[STAGES-1];
`ifdef ADDER_OVERFLOW_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Bench for pipelined_chunk_adder at WIDTH=16, CHUNK=4: vector table, stall sequence, reset flush.
// Latency: each table vector must produce out_valid exactly 4 cycles after it is presented.
// Backpressure: out_ready is dropped mid-stream; a scoreboard checks order and completeness.
module tb_pipelined_chunk_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic        ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [13];
  logic [17:0] exp_q [$];

  pipelined_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef ADDER_OVERFLOW_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} using the signed-sign rule for overflow.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] ye;
    logic [16:0] r;
    logic        ov;
    ye = sb ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {16'd0, (sb ? 1'b1 : ci)};
    ov = (x[15] == ye[15]) && (r[15] != x[15]);
`ifdef ADDER_OVERFLOW_FLAG_EN
    return {ov, r};
`else
    return {1'b0 & ov, r};
`endif
  endfunction

  function automatic logic [17:0] observed();
`ifdef ADDER_OVERFLOW_FLAG_EN
    return {ovf, cout, sum};
`else
    return {1'b0, cout, sum};
`endif
  endfunction

  // Scoreboard: push on acceptance, pop on delivery; sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_output", {14'd0, observed()}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_result", {14'd0, observed()}, {14'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_case(input int n_ops, input logic hold);
    int w;
    int seen;
    out_ready = !hold;
    for (int i = 0; i < n_ops; i++) begin
      in_valid = 1'b1; a = 16'(i * 3 + 1); b = 16'h0010; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (hold) begin
      w = 0;
      while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
      chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("rst_now_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_now_sum", {16'd0, sum}, 32'd0);
    chk("rst_now_cout", {31'd0, cout}, 32'd0);
`ifdef ADDER_OVERFLOW_FLAG_EN
    chk("rst_now_ovf", {31'd0, ovf}, 32'd0);
`endif
    exp_q.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("rst_no_stale_result", 32'(seen), 32'd0);
    chk("rst_in_ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int idx;
    int got;
    int cyc;
    logic acc;

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6]  = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[10] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[11] = '{16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0};
    vecs[12] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
`ifdef ADDER_OVERFLOW_FLAG_EN
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Single isolated operations: latency and value against the table.
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_sum", i), {16'd0, sum}, {16'd0, vecs[i].s});
      chk($sformatf("vec%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].co});
`ifdef ADDER_OVERFLOW_FLAG_EN
      chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ov});
`endif
    end
    @(posedge clk); #1;

    // Back-to-back stream with out_ready low in cycles 5..8 while the first result shows.
    idx = 0; got = 0; cyc = 0;
    while (got < 6 && cyc < 40) begin
      cyc++;
      in_valid = (idx < 6);
      a = 16'(idx + 1); b = 16'h0100; cin = 1'b0; sub = 1'b0;
      out_ready = !(cyc >= 5 && cyc <= 8);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!out_ready) begin
        chk($sformatf("stall_c%0d_in_ready", cyc), {31'd0, in_ready}, 32'd0);
        chk($sformatf("stall_c%0d_out_valid", cyc), {31'd0, out_valid}, 32'd1);
        chk($sformatf("stall_c%0d_hold_sum", cyc), {16'd0, sum}, 32'h0101);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stall_order_%0d", got), {16'd0, sum}, 32'h0101 + 32'(got));
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_delivered", 32'(got), 32'd6);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_no_duplicate", {31'd0, out_valid}, 32'd0);

    // Reset while operations are in flight, then while a result is stalled at the output.
    reset_case(3, 1'b0);
    reset_case(2, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
